// File: rtl/peak_meter_sched.sv
// peak_meter_sched: four-channel peak-hold meter sharing one compare/decrement
// datapath. Channels are granted round-robin; a TICK-driven timebase schedules
// a decay pass that walks channels 0..3 and lowers each non-zero peak by one.
// Optional sticky clip flags are built only when PEAK_METER_CLIP_EN is defined.

// Per-channel peak register: load from a winning sample or decrement on decay.
module peak_meter_lane #(
  parameter int DW = 12
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          wr_en,
  input  logic          dec_en,
  input  logic [DW-1:0] wr_dat,
  output logic [DW-1:0] peak
);
  // Sample write has priority; decay saturates at zero.
  always_ff @(posedge CLK) begin
    if (RESET)                      peak <= '0;
    else if (wr_en)                 peak <= wr_dat;
    else if (dec_en && peak != '0)  peak <= peak - 1'b1;
  end
endmodule

module peak_meter_sched #(
  parameter int            DW        = 12,
  parameter int            DECAY_DIV = 8,
  parameter logic [DW-1:0] CLIP_LVL  = 12'hFF0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            TICK,
  input  logic [3:0]      CH_REQ,
  input  logic [4*DW-1:0] CH_DAT,
  output logic [3:0]      CH_ACK,
  output logic [4*DW-1:0] MPEAK,
  output logic            UPD_STB,
  output logic [1:0]      UPD_CH,
  output logic            BUSY,
  output logic [3:0]      CLIP,
  input  logic [3:0]      CLIP_CLR
);
  typedef enum logic [1:0] {IDLE, GRANT, UPDATE, DECAY} state_t;

  localparam logic [7:0] DIV_LAST = 8'(DECAY_DIV - 1);

  state_t              state, nxt;
  logic [1:0]          rr_ptr, gnt_ch, win, rr_idx, dch;
  logic                found;
  logic [DW-1:0]       cap;
  logic [3:0][DW-1:0]  dat_a, pk_a;
  logic                tick_q, tick_ev, wrap, pend;
  logic [7:0]          dcnt;

  assign dat_a   = CH_DAT;
  assign MPEAK   = pk_a;
  assign tick_ev = TICK & ~tick_q;
  assign wrap    = tick_ev && (dcnt == DIV_LAST);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= nxt;
  end

  // Next state: a pending decay pass outranks channel requests.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (pend) nxt = DECAY;
               else if (|CH_REQ) nxt = GRANT;
      GRANT:   nxt = UPDATE;
      UPDATE:  nxt = IDLE;
      DECAY:   if (dch == 2'd3) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the strobe fires only on a strictly larger sample.
  always_comb begin
    CH_ACK  = '0;
    if (state == GRANT) CH_ACK[gnt_ch] = 1'b1;
    BUSY    = (state != IDLE);
    UPD_STB = (state == UPDATE) && (cap > pk_a[gnt_ch]);
    UPD_CH  = gnt_ch;
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    win    = rr_ptr;
    rr_idx = rr_ptr;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rr_idx = rr_ptr + 2'(i);
      if (!found && CH_REQ[rr_idx]) begin
        win   = rr_idx;
        found = 1'b1;
      end
    end
  end

  // Grant bookkeeping, sample capture and decay channel walk.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      gnt_ch <= '0;
      rr_ptr <= '0;
      cap    <= '0;
      dch    <= '0;
    end else begin
      if (state == IDLE && nxt == GRANT) gnt_ch <= win;
      if (state == GRANT) begin
        cap    <= dat_a[gnt_ch];
        rr_ptr <= gnt_ch + 2'd1;
      end
      dch <= (state == DECAY) ? dch + 2'd1 : 2'd0;
    end
  end

  // Decay timebase: count TICK rising edges, hold at most one pending pass.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_q <= 1'b0;
      dcnt   <= '0;
      pend   <= 1'b0;
    end else begin
      tick_q <= TICK;
      if (tick_ev) dcnt <= wrap ? 8'd0 : dcnt + 8'd1;
      if (state == DECAY && dch == 2'd3) pend <= 1'b0;
      else if (wrap)                     pend <= 1'b1;
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_lane
    peak_meter_lane #(.DW(DW)) u_lane (
      .CLK    (CLK),
      .RESET  (RESET),
      .wr_en  (UPD_STB && gnt_ch == 2'(n)),
      .dec_en (state == DECAY && dch == 2'(n)),
      .wr_dat (cap),
      .peak   (pk_a[n])
    );
  end

`ifdef PEAK_METER_CLIP_EN
  logic [3:0] clip_q, clip_set;
  assign clip_set = (state == UPDATE && cap >= CLIP_LVL) ? (4'b0001 << gnt_ch) : 4'b0000;
  assign CLIP     = clip_q;
  // Sticky clip flags; a same-cycle set beats the clear.
  always_ff @(posedge CLK) begin
    if (RESET) clip_q <= '0;
    else       clip_q <= (clip_q & ~CLIP_CLR) | clip_set;
  end
`else
  logic unused_clip;
  assign CLIP        = '0;
  assign unused_clip = ^{CLIP_CLR, CLIP_LVL};
`endif

endmodule

// File: doc/peak_meter_sched.md
PEAK_METER_SCHED -- requirements
Module: peak_meter_sched

Interface
REQ-001 The block SHALL have parameter DW, default 12, sample and peak width in bits.
REQ-002 The block SHALL have parameter DECAY_DIV, default 8, the number of TICK events per decay pass (legal range 1..255).
REQ-003 The block SHALL have parameter CLIP_LVL, default 12'hFF0, the clip threshold compared against DW-bit samples.
REQ-004 Port: CLK  in  1  single clock; all logic rising-edge.
REQ-005 Port: RESET  in  1  synchronous, active-high reset.
REQ-006 Port: TICK  in  1  decay timebase strobe, synchronous to CLK; each 0->1 transition is one event.
REQ-007 Port: CH_REQ  in  4  per-channel update request, one bit per channel.
REQ-008 Port: CH_DAT  in  4*DW  per-channel sample; channel n occupies bits [n*DW +: DW].
REQ-009 Port: CH_ACK  out  4  one-hot, one-cycle grant/capture acknowledge.
REQ-010 Port: MPEAK  out  4*DW  held peak per channel, same packing as CH_DAT.
REQ-011 Port: UPD_STB  out  1  one-cycle pulse when a channel's peak is written from a sample.
REQ-012 Port: UPD_CH  out  2  channel index qualified by UPD_STB.
REQ-013 Port: BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-014 Port: CLIP  out  4  sticky per-channel clip flags (see Configuration).
REQ-015 Port: CLIP_CLR  in  4  per-channel clip-flag clear pulses.

Function
REQ-016 The block SHALL time-share one compare/decrement datapath among 4 channels via the FSM states IDLE, GRANT, UPDATE and DECAY.
REQ-017 In IDLE with decay pending, the FSM SHALL enter DECAY; otherwise, with any CH_REQ high, it SHALL enter GRANT; otherwise it SHALL remain in IDLE.
REQ-018 The GRANT winner SHALL be chosen round-robin, starting the search at last-granted+1 modulo 4; after reset the search SHALL start at channel 0.
REQ-019 In GRANT the block SHALL assert CH_ACK[winner] for exactly that cycle, capture CH_DAT of the winner, and go to UPDATE.
REQ-020 A requester SHALL hold CH_REQ and CH_DAT stable until it sees ACK; if CH_REQ is still high in the cycle after ACK, the block SHALL treat it as a new request.
REQ-021 In UPDATE, if captured > MPEAK[ch], the block SHALL write MPEAK[ch] = captured and pulse UPD_STB with UPD_CH = ch; if equal or less, it SHALL make no write and no strobe. The FSM SHALL then return to IDLE.
REQ-022 Request-to-ACK latency SHALL be 1 cycle from an IDLE cycle in which CH_REQ is high, and the full transaction SHALL take 3 cycles (IDLE, GRANT, UPDATE).
REQ-023 An 8-bit decay counter SHALL increment on each TICK event; on reaching DECAY_DIV-1 it SHALL wrap to 0 and set decay pending.
REQ-024 A wrap occurring while decay is already pending SHALL be dropped, leaving at most one pending pass.
REQ-025 TICK events SHALL be counted in every FSM state.
REQ-026 DECAY SHALL last exactly 4 cycles, visiting channels 0..3 in order; each MPEAK > 0 SHALL decrement by 1, and MPEAK = 0 SHALL stay 0 (no wrap).
REQ-027 On exit from DECAY the block SHALL clear decay pending and return to IDLE.
REQ-028 Requests arriving during DECAY SHALL wait, and SHALL NOT be lost.
REQ-029 No ACK SHALL be issued in DECAY, and DECAY SHALL NOT assert UPD_STB.

Reset
REQ-030 On RESET high at a CLK edge, the block SHALL clear all of: FSM state (to IDLE), MPEAK, CH_ACK, UPD_STB, UPD_CH, BUSY, CLIP, decay counter, decay pending, round-robin pointer and the TICK edge-detect register.
REQ-031 A reset during GRANT, UPDATE or DECAY SHALL abort the operation without any partial MPEAK write on that edge.

Configuration
REQ-032 With PEAK_METER_CLIP_EN defined, CLIP[ch] SHALL set in the UPDATE cycle when captured >= CLIP_LVL, regardless of the peak comparison.
REQ-033 With PEAK_METER_CLIP_EN defined, CLIP_CLR[ch] SHALL clear CLIP[ch]; a set and a clear in the same cycle SHALL leave the flag set.
REQ-034 Without PEAK_METER_CLIP_EN, CLIP SHALL be constant 0, CLIP_CLR SHALL be ignored, and no clip logic SHALL be synthesised.

Verification
REQ-035 Scenario: reset, then CH_REQ=4'b0001 with ch0 data 12'h123 -> CH_ACK=4'b0001 one cycle later, then UPD_STB with UPD_CH=0, and MPEAK ch0 = 12'h123.
REQ-036 Scenario: CH_REQ=4'b1111 held -> ACK order ch0, ch1, ch2, ch3, ch0, with exactly 3 cycles between ACKs.
REQ-037 Scenario: ch2 peak 12'h005, 8 TICK events with DECAY_DIV=8 -> one DECAY pass, ch2 = 12'h004, a channel at 0 stays 0, and BUSY stays high for 4 cycles.
REQ-038 Scenario: decay pending and CH_REQ[1] high in the same IDLE cycle -> DECAY runs first, and CH_ACK[1] is asserted 1 cycle after DECAY ends.
REQ-039 Scenario: with PEAK_METER_CLIP_EN, ch3 sample 12'hFF0 -> CLIP[3]=1; CLIP_CLR[3] asserted together with a new 12'hFFF sample -> CLIP[3] stays 1.
REQ-040 Scenario: RESET asserted during UPDATE with sample 12'h800 -> MPEAK=0 and state IDLE the following cycle.
